// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv_mem_pkg
// Description : Shared types and constants for the unified memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package rv_mem_pkg;

    localparam int XLEN_DEFAULT = 32;

    // Requester identifiers
    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Fetch, load/store and memory-side signals of the port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if
    import rv_mem_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
);
    // Fetch requester
    logic            i_req;
    logic [XLEN-1:0] i_addr;
    logic            i_done;
    logic            i_err;
    logic [XLEN-1:0] i_rdata;

    // Load/store requester
    logic            d_req;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic            d_we;
    logic            d_done;
    logic            d_err;
    logic [XLEN-1:0] d_rdata;

    // Unified memory port
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_we;
    logic            mem_ready;
    logic [XLEN-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  i_req, i_addr, d_req, d_addr, d_wdata, d_we, mem_ready, mem_rdata,
        output i_done, i_err, i_rdata, d_done, d_err, d_rdata,
        output mem_req, mem_addr, mem_wdata, mem_we
    );

    // Requesters and memory model side
    modport master (
        output i_req, i_addr, d_req, d_addr, d_wdata, d_we, mem_ready, mem_rdata,
        input  i_done, i_err, i_rdata, d_done, d_err, d_rdata,
        input  mem_req, mem_addr, mem_wdata, mem_we
    );

endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter_wdog.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_wdog
// Description : Transaction watchdog; flags the last allowed wait cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arb_wdog #(
    parameter int TIMEOUT = 64
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_expired
);

    logic [7:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end
    end

    // Expiry marks the cycle the count reaches TIMEOUT-1, so the port is held TIMEOUT cycles
    generate
        if (TIMEOUT != 0) begin : g_wdog_on
            localparam logic [7:0] c_LIMIT = 8'(TIMEOUT - 1);
            assign o_expired = i_en && (r_count == c_LIMIT);
        end else begin : g_wdog_off
            assign o_expired = 1'b0;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one memory port between instruction fetch and load/store.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter
    import rv_mem_pkg::*;
#(
    parameter int XLEN       = XLEN_DEFAULT,
    parameter int MAX_CONSEC = 4,
    parameter int TIMEOUT    = 64
) (
    input wire logic          clk,
    input wire logic          rst_n,
    mem_port_arbiter_if.slave bus
);

    localparam logic [3:0] c_MAX_CONSEC = 4'(MAX_CONSEC);

    arb_state_t      r_state;
    logic [3:0]      r_fair;
    logic            r_mem_req;
    logic [XLEN-1:0] r_mem_addr;
    logic [XLEN-1:0] r_mem_wdata;
    logic            r_mem_we;
    logic            r_i_done;
    logic            r_i_err;
    logic [XLEN-1:0] r_i_rdata;
    logic            r_d_done;
    logic            r_d_err;
    logic [XLEN-1:0] r_d_rdata;

    logic            w_i_cand;
    logic            w_d_cand;
    logic            w_grant_i;
    logic            w_grant_d;
    logic            w_busy;
    logic            w_owner;
    logic            w_wd_expired;
    logic            w_finish;

    // A requester still seeing its completion pulse must not be re-granted
    assign w_i_cand  = bus.i_req && !(r_i_done || r_i_err);
    assign w_d_cand  = bus.d_req && !(r_d_done || r_d_err);
    assign w_grant_i = w_i_cand && (!w_d_cand || (r_fair == c_MAX_CONSEC));
    assign w_grant_d = w_d_cand && !w_grant_i;

    assign w_busy   = (r_state == BUSY_I) || (r_state == BUSY_D);
    assign w_owner  = (r_state == BUSY_I) ? REQ_I : REQ_D;
    assign w_finish = bus.mem_ready || w_wd_expired;

    mem_arb_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clr     (!w_busy),
        .i_en      (w_busy),
        .o_expired (w_wd_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_fair      <= '0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_i_done    <= 1'b0;
            r_i_err     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_done    <= 1'b0;
            r_d_err     <= 1'b0;
            r_d_rdata   <= '0;
        end else begin
            r_i_done <= 1'b0;
            r_i_err  <= 1'b0;
            r_d_done <= 1'b0;
            r_d_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_i) begin
                        r_mem_addr  <= bus.i_addr;
                        r_mem_wdata <= '0;
                        r_mem_we    <= 1'b0;
                        r_mem_req   <= 1'b1;
                        r_fair      <= '0;
                        r_state     <= BUSY_I;
                    end else if (w_grant_d) begin
                        r_mem_addr  <= bus.d_addr;
                        r_mem_wdata <= bus.d_wdata;
                        r_mem_we    <= bus.d_we;
                        r_mem_req   <= 1'b1;
                        if (bus.i_req && (r_fair != c_MAX_CONSEC)) begin
                            r_fair <= r_fair + 4'd1;
                        end
                        r_state     <= BUSY_D;
                    end
                end
                BUSY_I, BUSY_D: begin
                    // mem_ready takes priority over a simultaneous watchdog expiry
                    if (w_finish) begin
                        r_mem_req <= 1'b0;
                        r_state   <= RESP;
                        if (w_owner == REQ_I) begin
                            r_i_rdata <= bus.mem_ready ? bus.mem_rdata : '0;
                            r_i_done  <= bus.mem_ready;
                            r_i_err   <= !bus.mem_ready;
                        end else begin
                            r_d_rdata <= bus.mem_ready ? bus.mem_rdata : '0;
                            r_d_done  <= bus.mem_ready;
                            r_d_err   <= !bus.mem_ready;
                        end
                    end
                end
                RESP: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_we    = r_mem_we;
    assign bus.i_done    = r_i_done;
    assign bus.i_err     = r_i_err;
    assign bus.i_rdata   = r_i_rdata;
    assign bus.d_done    = r_d_done;
    assign bus.d_err     = r_d_err;
    assign bus.d_rdata   = r_d_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for the memory port arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    mem_port_arbiter_if #(.XLEN(32)) bus ();

    mem_port_arbiter #(
        .XLEN       (32),
        .MAX_CONSEC (4),
        .TIMEOUT    (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observe and drive 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_we = 1'b0;
        bus.mem_ready = 1'b0; bus.mem_rdata = '0;
        tick(); tick();
        n_cmp++;
        if ({bus.mem_req, bus.mem_we, bus.i_done, bus.i_err, bus.d_done, bus.d_err} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 000000",
                     {bus.mem_req, bus.mem_we, bus.i_done, bus.i_err, bus.d_done, bus.d_err});
        end
        n_cmp++;
        if ({bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata} !== 128'b0) begin
            n_bad++;
            $display("FAIL reset_data: got %h want 0",
                     {bus.mem_addr, bus.mem_wdata, bus.i_rdata, bus.d_rdata});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_fetch();
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0100;
        tick();
        n_cmp++;
        if ({bus.mem_req, bus.mem_we} !== 2'b10 || bus.mem_addr !== 32'h100 || bus.mem_wdata !== 32'h0) begin
            n_bad++;
            $display("FAIL fetch_launch: got req/we %b addr %h wdata %h want 10 100 0",
                     {bus.mem_req, bus.mem_we}, bus.mem_addr, bus.mem_wdata);
        end
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h0000_0013;
        tick();
        bus.mem_ready = 1'b0;
        n_cmp++;
        if (bus.i_done !== 1'b1 || bus.i_rdata !== 32'h13 || bus.mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL fetch_done: got done %b rdata %h req %b want 1 13 0",
                     bus.i_done, bus.i_rdata, bus.mem_req);
        end
        bus.i_req = 1'b0;
        tick();
        n_cmp++;
        if (bus.i_done !== 1'b0 || bus.i_rdata !== 32'h13) begin
            n_bad++;
            $display("FAIL fetch_after: got done %b rdata %h want 0 13", bus.i_done, bus.i_rdata);
        end
        tick();
    endtask

    task automatic test_single_store();
        int hi;
        int dn;
        bit ok;
        hi = 0; dn = 0; ok = 1'b1;
        bus.d_req = 1'b1; bus.d_addr = 32'h2000; bus.d_wdata = 32'hDEAD_BEEF; bus.d_we = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.mem_req) begin
                hi++;
                if (bus.mem_addr !== 32'h2000 || bus.mem_wdata !== 32'hDEAD_BEEF || bus.mem_we !== 1'b1)
                    ok = 1'b0;
            end
            if (bus.d_done) begin
                dn++;
                bus.d_req = 1'b0;
            end
            if (bus.i_done || bus.i_err || bus.d_err) ok = 1'b0;
            bus.mem_ready = (hi == 4) && bus.mem_req;
            bus.mem_rdata = 32'h55;
        end
        bus.mem_ready = 1'b0;
        n_cmp++;
        if (hi != 4) begin
            n_bad++;
            $display("FAIL store_req_cycles: got %0d want 4", hi);
        end
        n_cmp++;
        if (dn != 1) begin
            n_bad++;
            $display("FAIL store_done_count: got %0d want 1", dn);
        end
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL store_fields: got unstable fields or stray pulse want stable/none");
        end
    endtask

    task automatic test_contention();
        int g;
        int ic;
        int dc;
        logic [9:0] order;
        logic [9:0] exp_order;
        g = 0; ic = 0; dc = 0; order = '0;
        exp_order = 10'b10000_10000;
        bus.i_req = 1'b1; bus.i_addr = 32'h1000;
        bus.d_req = 1'b1; bus.d_addr = 32'h3000; bus.d_we = 1'b0; bus.d_wdata = 32'h0;
        for (int c = 0; c < 60 && g < 10; c++) begin
            tick();
            if (bus.i_done) ic++;
            if (bus.d_done) dc++;
            if (bus.mem_req) begin
                order[g] = (bus.mem_addr == 32'h1000);
                g++;
                bus.mem_ready = 1'b1;
                bus.mem_rdata = 32'(g);
            end else begin
                bus.mem_ready = 1'b0;
            end
        end
        tick();
        if (bus.i_done) ic++;
        if (bus.d_done) dc++;
        bus.i_req = 1'b0; bus.d_req = 1'b0; bus.mem_ready = 1'b0;
        n_cmp++;
        if (g != 10 || order !== exp_order) begin
            n_bad++;
            $display("FAIL contention_order: got %0d grants %b want 10 %b", g, order, exp_order);
        end
        n_cmp++;
        if (ic != 2 || dc != 8) begin
            n_bad++;
            $display("FAIL contention_dones: got i %0d d %0d want 2 8", ic, dc);
        end
        tick(); tick();
        n_cmp++;
        if (bus.mem_req !== 1'b0) begin
            n_bad++;
            $display("FAIL contention_idle: got mem_req %b want 0", bus.mem_req);
        end
    endtask

    task automatic test_timeout();
        int hi;
        bit seen;
        bit got_i;
        hi = 0; seen = 1'b0; got_i = 1'b0;
        bus.d_req = 1'b1; bus.d_addr = 32'h4000; bus.d_we = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            tick();
            if (bus.mem_req) hi++;
            if (c == 10) begin
                bus.i_req = 1'b1; bus.i_addr = 32'h1234;
            end
            if (bus.d_err) begin
                seen = 1'b1;
                bus.d_req = 1'b0;
                n_cmp++;
                if (bus.d_rdata !== 32'h0 || bus.d_done !== 1'b0 || bus.i_err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL timeout_err_data: got rdata %h done %b ierr %b want 0 0 0",
                             bus.d_rdata, bus.d_done, bus.i_err);
                end
            end
        end
        n_cmp++;
        if (!seen || hi != 64) begin
            n_bad++;
            $display("FAIL timeout_req_cycles: got err %b cycles %0d want 1 64", seen, hi);
        end
        for (int c = 0; c < 5 && !got_i; c++) begin
            tick();
            if (bus.mem_req) got_i = 1'b1;
        end
        n_cmp++;
        if (!got_i || bus.mem_addr !== 32'h1234 || bus.mem_we !== 1'b0) begin
            n_bad++;
            $display("FAIL timeout_next_grant: got req %b addr %h want 1 1234", got_i, bus.mem_addr);
        end
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hABCD;
        tick();
        bus.mem_ready = 1'b0; bus.i_req = 1'b0;
        n_cmp++;
        if (bus.i_done !== 1'b1 || bus.i_rdata !== 32'hABCD) begin
            n_bad++;
            $display("FAIL timeout_fetch_done: got done %b rdata %h want 1 abcd", bus.i_done, bus.i_rdata);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit relaunch;
        bit stray;
        relaunch = 1'b0; stray = 1'b0;
        bus.d_req = 1'b1; bus.d_addr = 32'h5000; bus.d_wdata = 32'h1111; bus.d_we = 1'b1;
        tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({bus.mem_req, bus.mem_we, bus.i_done, bus.i_err, bus.d_done, bus.d_err} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_async: got %b want 000000",
                     {bus.mem_req, bus.mem_we, bus.i_done, bus.i_err, bus.d_done, bus.d_err});
        end
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 5 && !relaunch; c++) begin
            tick();
            if (bus.d_done || bus.d_err) stray = 1'b1;
            if (bus.mem_req) relaunch = 1'b1;
        end
        n_cmp++;
        if (!relaunch || stray || bus.mem_addr !== 32'h5000 || bus.mem_we !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_relaunch: got req %b stray %b addr %h want 1 0 5000",
                     relaunch, stray, bus.mem_addr);
        end
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'h99;
        tick();
        bus.mem_ready = 1'b0; bus.d_req = 1'b0;
        n_cmp++;
        if (bus.d_done !== 1'b1 || bus.d_rdata !== 32'h99) begin
            n_bad++;
            $display("FAIL reset_relaunch_done: got done %b rdata %h want 1 99", bus.d_done, bus.d_rdata);
        end
        tick();
    endtask

    task automatic test_boundary();
        int hi;
        bit fin;
        hi = 0; fin = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 32'h600;
        for (int c = 0; c < 100 && !fin; c++) begin
            tick();
            if (bus.i_done || bus.i_err) begin
                fin = 1'b1;
                bus.i_req = 1'b0;
                n_cmp++;
                if (bus.i_done !== 1'b1 || bus.i_err !== 1'b0 || bus.i_rdata !== 32'h77) begin
                    n_bad++;
                    $display("FAIL boundary_ready_wins: got done %b err %b rdata %h want 1 0 77",
                             bus.i_done, bus.i_err, bus.i_rdata);
                end
            end
            if (bus.mem_req) hi++;
            bus.mem_ready = bus.mem_req && (hi == 64);
            bus.mem_rdata = 32'h77;
        end
        bus.mem_ready = 1'b0;
        n_cmp++;
        if (!fin || hi != 64) begin
            n_bad++;
            $display("FAIL boundary_cycles: got fin %b cycles %0d want 1 64", fin, hi);
        end
        tick(); tick();
        bus.mem_ready = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        tick();
        bus.mem_ready = 1'b0;
        tick();
        n_cmp++;
        if ({bus.mem_req, bus.i_done, bus.i_err, bus.d_done, bus.d_err} !== 5'b0 ||
            bus.i_rdata !== 32'h77 || bus.d_rdata !== 32'h99) begin
            n_bad++;
            $display("FAIL idle_ready_ignored: got ctl %b irdata %h drdata %h want 00000 77 99",
                     {bus.mem_req, bus.i_done, bus.i_err, bus.d_done, bus.d_err},
                     bus.i_rdata, bus.d_rdata);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_single_fetch();
        test_single_store();
        test_contention();
        test_timeout();
        test_reset_mid();
        test_boundary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
